// File: rtl/crc_byte_streamer_pkg.sv
// Shared types and constants for the CRC8816 byte streamer.
package crc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Initial value of the CRC8816 checker; used by reference models.
    localparam logic [7:0] CRC_INIT = 8'h0D;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4;

    typedef struct packed {
        logic match;
        logic timeout;
    } status_t;

endpackage

// File: rtl/crc_byte_streamer_if.sv
// Packet, CRC byte-stream and status handshakes of the CRC byte streamer.
interface crc_byte_streamer_if #(
    parameter int unsigned DATA_LENGTH = 32
);
    logic                   i_pkt_valid;
    logic                   o_pkt_ready;
    logic [DATA_LENGTH-1:0] i_pkt_data;
    logic [7:0]             i_pkt_crc;

    logic                   o_crc_valid;
    logic                   o_crc_last;
    logic [7:0]             o_crc_data;
    logic                   i_crc_done;
    logic                   i_crc_match;

    logic                   o_status_valid;
    logic                   i_status_ready;
    logic                   o_status_match;
    logic                   o_status_timeout;

    // The streamer itself.
    modport slave (
        input  i_pkt_valid, i_pkt_data, i_pkt_crc,
        input  i_crc_done, i_crc_match, i_status_ready,
        output o_pkt_ready, o_crc_valid, o_crc_last, o_crc_data,
        output o_status_valid, o_status_match, o_status_timeout
    );

    // Packet producer / checker / status consumer side.
    modport master (
        output i_pkt_valid, i_pkt_data, i_pkt_crc,
        output i_crc_done, i_crc_match, i_status_ready,
        input  o_pkt_ready, o_crc_valid, o_crc_last, o_crc_data,
        input  o_status_valid, o_status_match, o_status_timeout
    );
endinterface

// File: rtl/crc_byte_streamer_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/crc_byte_streamer.sv
// Feeds one packet word MSB-byte-first into the CRC8816 checker and reports
// match/timeout per packet, with saturating packet and error counters.
module crc_byte_streamer
    import crc_stream_pkg::*;
#(
    parameter int unsigned DATA_LENGTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    crc_byte_streamer_if.slave   bus,
    output logic [CNT_WIDTH-1:0] o_pkt_count,
    output logic [CNT_WIDTH-1:0] o_err_count
);
    localparam int unsigned DATA_LENGTH_BYTES = DATA_LENGTH / 8;
    localparam int unsigned SR_W   = DATA_LENGTH + 8;
    localparam int unsigned IDX_W  = $clog2(DATA_LENGTH_BYTES + 1);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sreg_q, sreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pkt_ready_q, pkt_ready_d;
    logic              crc_valid_q, crc_valid_d;
    logic              crc_last_q, crc_last_d;
    logic              status_valid_q, status_valid_d;
    status_t           status_q, status_d;

    logic pkt_hs;
    logic status_hs;
    logic err_inc;

    assign pkt_hs    = bus.i_pkt_valid & pkt_ready_q;
    assign status_hs = status_valid_q & bus.i_status_ready;
    assign err_inc   = status_hs & (~status_q.match | status_q.timeout);

    always_comb begin
        state_d        = state_q;
        sreg_d         = sreg_q;
        idx_d          = idx_q;
        wcnt_d         = wcnt_q;
        pkt_ready_d    = pkt_ready_q;
        crc_valid_d    = crc_valid_q;
        crc_last_d     = crc_last_q;
        status_valid_d = status_valid_q;
        status_d       = status_q;

        case (state_q)
            IDLE: begin
                pkt_ready_d = 1'b1;
                if (pkt_hs) begin
                    sreg_d      = {bus.i_pkt_data, bus.i_pkt_crc};
                    idx_d       = '0;
                    pkt_ready_d = 1'b0;
                    crc_valid_d = 1'b1;
                    crc_last_d  = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // Zeros shift in behind the CRC byte, so the data output
                // returns to 0 on its own once the last byte has gone out.
                sreg_d = sreg_q << 8;
                if (idx_q == IDX_W'(DATA_LENGTH_BYTES)) begin
                    crc_valid_d = 1'b0;
                    crc_last_d  = 1'b0;
                    wcnt_d      = WCNT_W'(1);
                    state_d     = WAIT;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    crc_last_d = (idx_q == IDX_W'(DATA_LENGTH_BYTES - 1));
                end
            end
            WAIT: begin
                if (bus.i_crc_done) begin
                    status_d.match   = bus.i_crc_match;
                    status_d.timeout = 1'b0;
                    status_valid_d   = 1'b1;
                    state_d          = REPORT;
                end else if (wcnt_q == WCNT_W'(TIMEOUT_CYCLES)) begin
                    status_d.match   = 1'b0;
                    status_d.timeout = 1'b1;
                    status_valid_d   = 1'b1;
                    state_d          = REPORT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            REPORT: begin
                if (status_hs) begin
                    status_valid_d = 1'b0;
                    status_d       = '0;
                    pkt_ready_d    = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            sreg_q         <= '0;
            idx_q          <= '0;
            wcnt_q         <= '0;
            pkt_ready_q    <= 1'b0;
            crc_valid_q    <= 1'b0;
            crc_last_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_q       <= '0;
        end else begin
            state_q        <= state_d;
            sreg_q         <= sreg_d;
            idx_q          <= idx_d;
            wcnt_q         <= wcnt_d;
            pkt_ready_q    <= pkt_ready_d;
            crc_valid_q    <= crc_valid_d;
            crc_last_q     <= crc_last_d;
            status_valid_q <= status_valid_d;
            status_q       <= status_d;
        end
    end

    assign bus.o_pkt_ready      = pkt_ready_q;
    assign bus.o_crc_valid      = crc_valid_q;
    assign bus.o_crc_last       = crc_last_q;
    assign bus.o_crc_data       = sreg_q[SR_W-1 -: 8];
    assign bus.o_status_valid   = status_valid_q;
    assign bus.o_status_match   = status_q.match;
    assign bus.o_status_timeout = status_q.timeout;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (status_hs),
        .clear (1'b0),
        .count (o_pkt_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (err_inc),
        .clear (1'b0),
        .count (o_err_count)
    );
endmodule

// File: tb/tb_crc_byte_streamer.sv
// Directed self-checking bench for crc_byte_streamer with a mock CRC8816 checker.
module tb_crc_byte_streamer;
    logic       clk;
    logic       reset;
    logic [3:0] pkt_count;
    logic [3:0] err_count;
    int         tests;
    int         fails;

    crc_byte_streamer_if #(.DATA_LENGTH(32)) bus ();

    crc_byte_streamer #(
        .DATA_LENGTH    (32),
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_pkt_count (pkt_count),
        .o_err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Handshakes one packet and checks each byte on the CRC interface.
    // Returns at the negedge of the cycle carrying the last (CRC) byte.
    task automatic send_pkt(input logic [31:0] d, input logic [7:0] c);
        logic [39:0] w;
        w = {d, c};
        chk("pkt_ready_idle", 32'(bus.o_pkt_ready), 32'd1);
        bus.i_pkt_valid = 1'b1;
        bus.i_pkt_data  = d;
        bus.i_pkt_crc   = c;
        step();
        bus.i_pkt_valid = 1'b0;
        bus.i_pkt_data  = '0;
        bus.i_pkt_crc   = '0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            chk("crc_valid", 32'(bus.o_crc_valid), 32'd1);
            chk("crc_data",  32'(bus.o_crc_data),  32'(w[39-8*k -: 8]));
            chk("crc_last",  32'(bus.o_crc_last),  32'(k == 4));
            chk("pkt_ready_busy", 32'(bus.o_pkt_ready), 32'd0);
        end
    endtask

    task automatic status_handshake(input logic [3:0] exp_pkt, input logic [3:0] exp_err);
        bus.i_status_ready = 1'b1;
        step();
        bus.i_status_ready = 1'b0;
        chk("status_valid_after_hs", 32'(bus.o_status_valid), 32'd0);
        chk("pkt_ready_after_hs",    32'(bus.o_pkt_ready),    32'd1);
        chk("pkt_count", 32'(pkt_count), 32'(exp_pkt));
        chk("err_count", 32'(err_count), 32'(exp_err));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.i_pkt_valid    = 1'b0;
        bus.i_pkt_data     = '0;
        bus.i_pkt_crc      = '0;
        bus.i_crc_done     = 1'b0;
        bus.i_crc_match    = 1'b0;
        bus.i_status_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_pkt_ready",    32'(bus.o_pkt_ready),    32'd0);
        chk("rst_crc_valid",    32'(bus.o_crc_valid),    32'd0);
        chk("rst_crc_data",     32'(bus.o_crc_data),     32'd0);
        chk("rst_status_valid", 32'(bus.o_status_valid), 32'd0);
        chk("rst_pkt_count",    32'(pkt_count),          32'd0);
        chk("rst_err_count",    32'(err_count),          32'd0);
        reset = 1'b1;
        step();

        // Good packet: done+match two cycles after last
        send_pkt(32'hDEADBEEF, 8'h5A);
        step();
        chk("wait_crc_valid", 32'(bus.o_crc_valid), 32'd0);
        chk("wait_crc_data",  32'(bus.o_crc_data),  32'd0);
        chk("wait_crc_last",  32'(bus.o_crc_last),  32'd0);
        step();
        bus.i_crc_done  = 1'b1;
        bus.i_crc_match = 1'b1;
        step();
        bus.i_crc_done  = 1'b0;
        bus.i_crc_match = 1'b0;
        chk("good_status_valid", 32'(bus.o_status_valid),   32'd1);
        chk("good_match",        32'(bus.o_status_match),   32'd1);
        chk("good_timeout",      32'(bus.o_status_timeout), 32'd0);
        status_handshake(4'd1, 4'd0);

        // Mismatch: done with match=0 one cycle after last
        send_pkt(32'hDEADBEEF, 8'h5A);
        step();
        bus.i_crc_done  = 1'b1;
        bus.i_crc_match = 1'b0;
        step();
        bus.i_crc_done  = 1'b0;
        chk("mis_status_valid", 32'(bus.o_status_valid),   32'd1);
        chk("mis_match",        32'(bus.o_status_match),   32'd0);
        chk("mis_timeout",      32'(bus.o_status_timeout), 32'd0);
        status_handshake(4'd2, 4'd1);

        // Timeout: no done; decided in the 4th wait cycle, visible the next
        send_pkt(32'h00FF00FF, 8'h3C);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("to_not_yet", 32'(bus.o_status_valid), 32'd0);
        end
        step();
        chk("to_status_valid", 32'(bus.o_status_valid),   32'd1);
        chk("to_match",        32'(bus.o_status_match),   32'd0);
        chk("to_timeout",      32'(bus.o_status_timeout), 32'd1);

        // Backpressure: status held 10 cycles; done/match in REPORT ignored
        bus.i_crc_done  = 1'b1;
        bus.i_crc_match = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_status_valid", 32'(bus.o_status_valid),   32'd1);
            chk("bp_match",        32'(bus.o_status_match),   32'd0);
            chk("bp_timeout",      32'(bus.o_status_timeout), 32'd1);
            chk("bp_pkt_ready",    32'(bus.o_pkt_ready),      32'd0);
            chk("bp_crc_valid",    32'(bus.o_crc_valid),      32'd0);
        end
        bus.i_crc_done  = 1'b0;
        bus.i_crc_match = 1'b0;
        status_handshake(4'd3, 4'd2);

        // Done on the 4th wait cycle beats the timeout
        send_pkt(32'h12345678, 8'h9A);
        step();
        step();
        step();
        step();
        bus.i_crc_done  = 1'b1;
        bus.i_crc_match = 1'b1;
        step();
        bus.i_crc_done  = 1'b0;
        bus.i_crc_match = 1'b0;
        chk("dw_status_valid", 32'(bus.o_status_valid),   32'd1);
        chk("dw_match",        32'(bus.o_status_match),   32'd1);
        chk("dw_timeout",      32'(bus.o_status_timeout), 32'd0);
        status_handshake(4'd4, 4'd2);

        // Reset mid-packet after two bytes
        bus.i_pkt_valid = 1'b1;
        bus.i_pkt_data  = 32'h11223344;
        bus.i_pkt_crc   = 8'h77;
        step();
        bus.i_pkt_valid = 1'b0;
        chk("mid_byte0", 32'(bus.o_crc_data), 32'h11);
        step();
        chk("mid_byte1", 32'(bus.o_crc_data), 32'h22);
        #2 reset = 1'b0;
        #1;
        chk("mid_crc_valid",    32'(bus.o_crc_valid),    32'd0);
        chk("mid_crc_data",     32'(bus.o_crc_data),     32'd0);
        chk("mid_status_valid", 32'(bus.o_status_valid), 32'd0);
        chk("mid_pkt_ready",    32'(bus.o_pkt_ready),    32'd0);
        chk("mid_pkt_count",    32'(pkt_count),          32'd0);
        chk("mid_err_count",    32'(err_count),          32'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_status_valid", 32'(bus.o_status_valid), 32'd0);
        chk("post_rst_crc_valid",    32'(bus.o_crc_valid),    32'd0);
        send_pkt(32'h01020304, 8'hAA);
        step();
        bus.i_crc_done  = 1'b1;
        bus.i_crc_match = 1'b1;
        step();
        bus.i_crc_done  = 1'b0;
        bus.i_crc_match = 1'b0;
        chk("post_rst_match", 32'(bus.o_status_match), 32'd1);
        status_handshake(4'd1, 4'd0);

        // Saturation: 17 mismatching packets from cleared counters
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        for (int n = 1; n <= 17; n++) begin
            send_pkt(32'hA5A5A5A5 ^ 32'(n), 8'(n));
            step();
            bus.i_crc_done  = 1'b1;
            bus.i_crc_match = 1'b0;
            step();
            bus.i_crc_done  = 1'b0;
            chk("sat_status_valid", 32'(bus.o_status_valid), 32'd1);
            status_handshake(4'((n > 15) ? 15 : n), 4'((n > 15) ? 15 : n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
